// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one load/store unit between N_REQ requesters.
// One transaction in flight; per-transaction timeout with error pulse back to the requester.
module lsu_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_read_i,
    input  logic [N_REQ-1:0]       req_write_i,
    input  logic [N_REQ-1:0][31:0] req_addr_i,
    input  logic [N_REQ-1:0][31:0] req_data_i,
    output logic [31:0]            req_data_o,
    output logic [N_REQ-1:0]       req_valid_o,
    output logic [N_REQ-1:0]       req_err_o,
    output logic                   lsu_read_o,
    output logic                   lsu_write_o,
    output logic [31:0]            lsu_addr_o,
    output logic [31:0]            lsu_data_o,
    input  logic [31:0]            lsu_data_i,
    input  logic                   lsu_valid_i
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Counter only needs to hold 0..TIMEOUT-1: the timeout fires on the edge it would reach TIMEOUT.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [PW-1:0]     grant_reg, grant_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              rd_reg, rd_next;
    logic              wr_reg, wr_next;
    logic [31:0]       addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic [N_REQ-1:0]  valid_reg, valid_next;
    logic [N_REQ-1:0]  err_reg, err_next;

    logic [N_REQ-1:0]  req_any;
    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     grant_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_any
            assign req_any[gi] = req_read_i[gi] | req_write_i[gi];
        end
    endgenerate

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int            sum;
            logic [PW-1:0] cand;
            sum = int'(ptr_reg) + i;
            if (sum >= N_REQ) sum = sum - N_REQ;
            cand = PW'(sum);
            if (req_any[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign grant_inc = (grant_reg == LAST_IDX) ? '0 : grant_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        cnt_next   = cnt_reg;
        rd_next    = rd_reg;
        wr_next    = wr_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        valid_next = '0;
        err_next   = '0;
        unique case (state_reg)
            S_IDLE: begin
                if (pick_found) begin
                    grant_next = pick_idx;
                    addr_next  = req_addr_i[pick_idx];
                    wdata_next = req_data_i[pick_idx];
                    // A write needs both strobes; any other request is a read.
                    wr_next    = req_read_i[pick_idx] & req_write_i[pick_idx];
                    rd_next    = ~(req_read_i[pick_idx] & req_write_i[pick_idx]);
                    cnt_next   = '0;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (lsu_valid_i) begin
                    rd_next               = 1'b0;
                    wr_next               = 1'b0;
                    if (rd_reg) rdata_next = lsu_data_i;
                    valid_next[grant_reg] = 1'b1;
                    ptr_next              = grant_inc;
                    state_next            = S_DONE;
                end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
                    rd_next             = 1'b0;
                    wr_next             = 1'b0;
                    err_next[grant_reg] = 1'b1;
                    ptr_next            = grant_inc;
                    state_next          = S_DONE;
                end else if (TO_EN) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            ptr_reg   <= '0;
            grant_reg <= '0;
            cnt_reg   <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            valid_reg <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            cnt_reg   <= cnt_next;
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    assign lsu_read_o  = rd_reg;
    assign lsu_write_o = wr_reg;
    assign lsu_addr_o  = addr_reg;
    assign lsu_data_o  = wdata_reg;
    assign req_data_o  = rdata_reg;
    assign req_valid_o = valid_reg;
    assign req_err_o   = err_reg;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios then randomized transactions against a
// transaction-level model (round-robin pointer, last read data).
module tb_lsu_arbiter;

    localparam int N  = 2;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_read_i, req_write_i;
    logic [N-1:0][31:0] req_addr_i, req_data_i;
    logic [31:0]       req_data_o;
    logic [N-1:0]      req_valid_o, req_err_o;
    logic              lsu_read_o, lsu_write_o;
    logic [31:0]       lsu_addr_o, lsu_data_o;
    logic [31:0]       lsu_data_i;
    logic              lsu_valid_i;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr_m   = 0;
    logic [31:0] data_m = '0;

    lsu_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_i(rst_i),
        .req_read_i(req_read_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_data_o(req_data_o), .req_valid_o(req_valid_o), .req_err_o(req_err_o),
        .lsu_read_o(lsu_read_o), .lsu_write_o(lsu_write_o),
        .lsu_addr_o(lsu_addr_o), .lsu_data_o(lsu_data_o),
        .lsu_data_i(lsu_data_i), .lsu_valid_i(lsu_valid_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] any, input int p);
        for (int i = 0; i < N; i++)
            if (any[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Starts at a negedge with the DUT idle; ends at the negedge of the following idle cycle.
    // lat = BUSY cycle index on which the LSU answers; lat >= TO means it never answers.
    task automatic txn(input logic [N-1:0] rd, input logic [N-1:0] wr, input int lat,
                       input bit fix, input logic [31:0] a_fix, input logic [31:0] d_fix,
                       input logic [31:0] r_fix);
        int g;
        bit w, ok;
        logic [31:0] ea, ed, rdat;
        logic [N-1:0] onehot;
        req_read_i  = rd;
        req_write_i = wr;
        for (int i = 0; i < N; i++) begin
            req_addr_i[i] = fix ? a_fix : $urandom;
            req_data_i[i] = fix ? d_fix : $urandom;
        end
        g  = pick(rd | wr, ptr_m);
        w  = rd[g] & wr[g];
        ea = req_addr_i[g];
        ed = req_data_i[g];
        ok = 1'b0;
        rdat = '0;
        @(negedge clk);
        for (int k = 0; k < TO; k++) begin
            chk("busy_rd", lsu_read_o, !w);
            chk("busy_wr", lsu_write_o, w);
            chk("busy_addr", lsu_addr_o, ea);
            chk("busy_data", lsu_data_o, ed);
            chk("busy_valid", req_valid_o, '0);
            for (int i = 0; i < N; i++) begin
                req_addr_i[i] = $urandom;
                req_data_i[i] = $urandom;
            end
            lsu_data_i  = fix ? r_fix : $urandom;
            lsu_valid_i = (k == lat);
            if (k == lat) rdat = lsu_data_i;
            @(negedge clk);
            lsu_valid_i = 1'b0;
            if (k == lat) begin
                ok = 1'b1;
                break;
            end
        end
        onehot = '0;
        onehot[g] = 1'b1;
        if (ok && !w) data_m = rdat;
        $display("[TB] txn grant=%0d %s lat=%0d -> %s", g, w ? "write" : "read", lat,
                 ok ? "ok" : "timeout");
        chk("done_rd", lsu_read_o, 1'b0);
        chk("done_wr", lsu_write_o, 1'b0);
        chk("done_valid", req_valid_o, ok ? onehot : '0);
        chk("done_err", req_err_o, ok ? '0 : onehot);
        chk("done_rdata", req_data_o, data_m);
        ptr_m = (g + 1) % N;
        lsu_valid_i = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        lsu_valid_i = 1'b0;
        chk("idle_valid", req_valid_o, '0);
        chk("idle_err", req_err_o, '0);
        chk("idle_rd", lsu_read_o, 1'b0);
        chk("idle_rdata", req_data_o, data_m);
    endtask

    initial begin
        logic [N-1:0] rr, ww;
        rst_i = 1'b1;
        req_read_i = '0; req_write_i = '0;
        req_addr_i = '0; req_data_i = '0;
        lsu_data_i = '0; lsu_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd", lsu_read_o, 1'b0);
        chk("rst_wr", lsu_write_o, 1'b0);
        chk("rst_addr", lsu_addr_o, '0);
        chk("rst_rdata", req_data_o, '0);
        chk("rst_valid", req_valid_o, '0);
        chk("rst_err", req_err_o, '0);
        rst_i = 1'b0;

        // No request stays idle; a stray LSU valid in idle changes nothing.
        repeat (3) begin
            @(negedge clk);
            chk("noreq_rd", lsu_read_o | lsu_write_o, 1'b0);
        end
        lsu_data_i = 32'hCAFEF00D;
        lsu_valid_i = 1'b1;
        @(negedge clk);
        lsu_valid_i = 1'b0;
        chk("stray_valid", req_valid_o, '0);
        chk("stray_rdata", req_data_o, data_m);
        chk("stray_rd", lsu_read_o, 1'b0);

        txn(2'b01, 2'b00, 2, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF);
        chk("single_read_data", req_data_o, 32'hDEADBEEF);
        txn(2'b10, 2'b10, 1, 1'b1, 32'h40, 32'h1234, 32'h5555AAAA);
        for (int i = 0; i < 4; i++) txn(2'b11, 2'b00, i % 3, 1'b0, '0, '0, '0);
        txn(2'b11, 2'b00, 99, 1'b0, '0, '0, '0);
        txn(2'b11, 2'b00, TO - 1, 1'b0, '0, '0, '0);
        txn(2'b01, 2'b00, 0, 1'b0, '0, '0, '0);

        // Reset while BUSY, with ptr at 1.
        req_read_i = 2'b11;
        @(negedge clk);
        chk("pre_rst_busy", lsu_read_o, 1'b1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        req_read_i = '0;
        ptr_m = 0;
        data_m = '0;
        chk("midrst_rd", lsu_read_o, 1'b0);
        chk("midrst_addr", lsu_addr_o, '0);
        chk("midrst_data", lsu_data_o, '0);
        chk("midrst_rdata", req_data_o, '0);
        chk("midrst_valid", req_valid_o, '0);
        lsu_valid_i = 1'b1;
        @(negedge clk);
        lsu_valid_i = 1'b0;
        chk("postrst_valid", req_valid_o, '0);
        chk("postrst_err", req_err_o, '0);
        txn(2'b11, 2'b00, 1, 1'b0, '0, '0, '0);

        for (int t = 0; t < 40; t++) begin
            do begin
                rr = N'($urandom);
                ww = N'($urandom);
            end while ((rr | ww) == '0);
            txn(rr, ww, $urandom_range(0, TO + 1), 1'b0, '0, '0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waited for lsu_valid_i (0 = no timeout).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_read_i  input  N_REQ  per-requester read request, level, held until acknowledged.
REQ-006 SHALL have port req_write_i  input  N_REQ  per-requester write request, level, held until acknowledged.
REQ-007 SHALL have port req_addr_i  input  N_REQ x 32  per-requester address.
REQ-008 SHALL have port req_data_i  input  N_REQ x 32  per-requester write data.
REQ-009 SHALL have port req_data_o  output  32  read data returned to the acknowledged requester.
REQ-010 SHALL have port req_valid_o  output  N_REQ  one-hot completion pulse.
REQ-011 SHALL have port req_err_o  output  N_REQ  one-hot timeout pulse.
REQ-012 SHALL have port lsu_read_o  output  1  read command to the shared LSU.
REQ-013 SHALL have port lsu_write_o  output  1  write command to the shared LSU.
REQ-014 SHALL have port lsu_addr_o  output  32  address to the LSU.
REQ-015 SHALL have port lsu_data_o  output  32  write data to the LSU.
REQ-016 SHALL have port lsu_data_i  input  32  read data from the LSU.
REQ-017 SHALL have port lsu_valid_i  input  1  single-cycle LSU completion pulse.

Function
REQ-018 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-019 In IDLE, SHALL select the first requester with read or write asserted, searching round-robin from index ptr; no request keeps IDLE.
REQ-020 On grant, SHALL register grant index, address, data and command, enter BUSY, and assert lsu_read_o/lsu_write_o from the next cycle (1-cycle request-to-LSU latency).
REQ-021 SHALL issue a write only when the granted requester asserts both read and write.
REQ-022 In BUSY, SHALL hold lsu_* outputs constant regardless of requester input changes.
REQ-023 On lsu_valid_i in BUSY: SHALL deassert lsu_read_o/lsu_write_o, register lsu_data_i into req_data_o (reads only; writes leave it unchanged), pulse req_valid_o[grant] for exactly one cycle, set ptr = (grant+1) mod N_REQ, and enter DONE.
REQ-024 DONE SHALL last exactly one cycle with no grant, letting the acknowledged requester drop its request.
REQ-025 With TIMEOUT>0, a cycle counter SHALL start at 0 on entering BUSY; when it reaches TIMEOUT without lsu_valid_i, SHALL drop lsu commands, pulse req_err_o[grant] one cycle (req_valid_o stays 0), advance ptr and enter DONE.
REQ-026 lsu_valid_i arriving in the same cycle the counter reaches TIMEOUT SHALL count as success, not error.
REQ-027 lsu_valid_i in IDLE or DONE SHALL be ignored.
REQ-028 req_data_o SHALL hold its last value until the next read completion.
REQ-029 Under continuous requests from all N_REQ requesters, each SHALL be served once per N_REQ transactions.

Reset
REQ-030 When rst_i is high at a clock edge, SHALL enter IDLE, ptr = 0, counter = 0, and all outputs 0 (lsu_*, req_data_o, req_valid_o, req_err_o) from that edge, including mid-BUSY; no valid/err pulse for the aborted transaction.

Verification
REQ-031 Single read: req_read_i[0]=1, addr 0x10; LSU returns 0xDEADBEEF after 3 cycles -> lsu_read_o high 1 cycle after request, lsu_addr_o=0x10, req_valid_o=01 for 1 cycle, req_data_o=0xDEADBEEF.
REQ-032 Contention: both requesters read continuously, ptr=0 -> grant order 0,1,0,1; each req_valid_o pulse separated by DONE cycle.
REQ-033 Read+write: req_read_i[1]=req_write_i[1]=1, data 0x1234 -> lsu_write_o=1, lsu_read_o=0, lsu_data_o=0x1234, req_data_o unchanged.
REQ-034 Timeout: TIMEOUT=4, no lsu_valid_i -> commands drop after 4 BUSY cycles, req_err_o[0] pulses, req_valid_o stays 0, next grant to requester 1.
REQ-035 Reset in BUSY: rst_i high for 1 cycle while waiting -> all outputs 0 next cycle, later lsu_valid_i ignored, next grant starts from requester 0.
REQ-036 Stray valid: lsu_valid_i pulse in IDLE -> no output change.
